// File: rtl/wishbone_sram_slave.sv
// Wishbone classic slave that bridges single transfers onto an asynchronous
// 32-bit SRAM. Read strobe and write pulse lengths are set by parameters.
// Every output comes straight from a flop, so pad timing is predictable.
module wishbone_sram_slave #(
    parameter int WAIT_RD = 2,  // read strobe length in clk cycles, 1..15
    parameter int WAIT_WR = 2   // write-enable pulse length in clk cycles, 1..15
) (
    input  logic        clk,
    input  logic        rst,              // asynchronous, active-low

    // Wishbone slave side
    input  logic        wishbone_cyc_i,
    input  logic        wishbone_stb_i,
    input  logic        wishbone_we_i,
    input  logic [3:0]  wishbone_sel_i,
    input  logic [31:0] wishbone_addr_i,
    input  logic [31:0] wishbone_data_i,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_ack_o,

    // SRAM side
    output logic [19:0] sram_addr_o,
    input  logic [31:0] sram_data_i,
    output logic [31:0] sram_data_o,
    output logic        sram_data_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n
);

    // The wait counter is reloaded with (length - 1) so that the strobe is
    // asserted for exactly "length" cycles while counting down to zero.
    localparam logic [3:0] RD_LOAD = 4'(WAIT_RD - 1);
    localparam logic [3:0] WR_LOAD = 4'(WAIT_WR - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR      = 3'd2,
        WR_HOLD = 3'd3,
        ACK     = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    // Set when the master abandoned a write; WR_HOLD then returns to IDLE
    // without acknowledging.
    logic       abort_wr;

    // Only the word address bits [21:2] reach the SRAM; the rest are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wishbone_addr_i[31:22], wishbone_addr_i[1:0]};

    // Transfer sequencer: the latched request lives in the SRAM-side output
    // registers (sram_addr_o, sram_data_o, sram_be_n), so later changes on
    // the Wishbone inputs cannot affect a transfer once it has started.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            wait_cnt        <= 4'd0;
            abort_wr        <= 1'b0;
            wishbone_ack_o  <= 1'b0;
            wishbone_data_o <= 32'h0;
            sram_addr_o     <= 20'h0;
            sram_data_o     <= 32'h0;
            sram_data_oe    <= 1'b0;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_we_n       <= 1'b1;
            sram_be_n       <= 4'hF;
        end else begin
            // Ack is a single-cycle pulse; only the transition into ACK sets it.
            wishbone_ack_o <= 1'b0;

            case (state)
                IDLE: begin
                    sram_ce_n    <= 1'b1;
                    sram_oe_n    <= 1'b1;
                    sram_we_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                    abort_wr     <= 1'b0;
                    if (wishbone_cyc_i && wishbone_stb_i) begin
                        sram_addr_o <= wishbone_addr_i[21:2];
                        sram_data_o <= wishbone_data_i;
                        sram_be_n   <= ~wishbone_sel_i;
                        if (wishbone_we_i) begin
                            if (wishbone_sel_i == 4'h0) begin
                                // Nothing to write: acknowledge without touching the SRAM.
                                state          <= ACK;
                                wait_cnt       <= 4'd0;
                                wishbone_ack_o <= 1'b1;
                            end else begin
                                state        <= WR;
                                wait_cnt     <= WR_LOAD;
                                sram_ce_n    <= 1'b0;
                                sram_we_n    <= 1'b0;
                                sram_data_oe <= 1'b1;
                            end
                        end else begin
                            state     <= RD;
                            wait_cnt  <= RD_LOAD;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                        end
                    end
                end

                RD: begin
                    if (!wishbone_cyc_i) begin
                        // Master gave up: release the SRAM, keep the old read data.
                        state     <= IDLE;
                        wait_cnt  <= 4'd0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                    end else if (wait_cnt == 4'd0) begin
                        // Last strobe cycle: SRAM data has settled, capture it.
                        state           <= ACK;
                        wishbone_data_o <= sram_data_i;
                        wishbone_ack_o  <= 1'b1;
                        sram_ce_n       <= 1'b1;
                        sram_oe_n       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WR: begin
                    if (!wishbone_cyc_i || wait_cnt == 4'd0) begin
                        // End the write pulse; address/data stay driven one more
                        // cycle for hold time even when the write was abandoned.
                        state     <= WR_HOLD;
                        wait_cnt  <= 4'd0;
                        sram_we_n <= 1'b1;
                        abort_wr  <= !wishbone_cyc_i;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WR_HOLD: begin
                    sram_ce_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                    abort_wr     <= 1'b0;
                    if (abort_wr) begin
                        state <= IDLE;
                    end else begin
                        state          <= ACK;
                        wishbone_ack_o <= 1'b1;
                    end
                end

                ACK: begin
                    // Strobes are already released; wait one cycle in IDLE
                    // before the next request can be taken.
                    state        <= IDLE;
                    sram_ce_n    <= 1'b1;
                    sram_oe_n    <= 1'b1;
                    sram_we_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    wait_cnt     <= 4'd0;
                    abort_wr     <= 1'b0;
                    sram_ce_n    <= 1'b1;
                    sram_oe_n    <= 1'b1;
                    sram_we_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// Self-checking bench for wishbone_sram_slave: directed latency/abort/reset
// cases followed by randomized transfers against a word-level memory model.
module tb_wishbone_sram_slave;

    localparam int WRD = 2;
    localparam int WWR = 2;

    logic        clk;
    logic        rst;
    logic        wishbone_cyc_i;
    logic        wishbone_stb_i;
    logic        wishbone_we_i;
    logic [3:0]  wishbone_sel_i;
    logic [31:0] wishbone_addr_i;
    logic [31:0] wishbone_data_i;
    logic [31:0] wishbone_data_o;
    logic        wishbone_ack_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_data_i;
    logic [31:0] sram_data_o;
    logic        sram_data_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Physical SRAM device and the bench's expected memory contents.
    logic [31:0] sram_mem [logic [19:0]];
    logic [31:0] ref_mem  [logic [19:0]];
    logic [19:0] pool [8];
    logic [31:0] exp_data_o;

    wishbone_sram_slave #(.WAIT_RD(WRD), .WAIT_WR(WWR)) dut (
        .clk             (clk),
        .rst             (rst),
        .wishbone_cyc_i  (wishbone_cyc_i),
        .wishbone_stb_i  (wishbone_stb_i),
        .wishbone_we_i   (wishbone_we_i),
        .wishbone_sel_i  (wishbone_sel_i),
        .wishbone_addr_i (wishbone_addr_i),
        .wishbone_data_i (wishbone_data_i),
        .wishbone_data_o (wishbone_data_o),
        .wishbone_ack_o  (wishbone_ack_o),
        .sram_addr_o     (sram_addr_o),
        .sram_data_i     (sram_data_i),
        .sram_data_o     (sram_data_o),
        .sram_data_oe    (sram_data_oe),
        .sram_ce_n       (sram_ce_n),
        .sram_oe_n       (sram_oe_n),
        .sram_we_n       (sram_we_n),
        .sram_be_n       (sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM device: byte-masked write on each clock edge while CE and WE are low.
    always @(posedge clk) begin : sram_write
        logic [31:0] w;
        if (rst && !sram_ce_n && !sram_we_n) begin
            w = sram_mem.exists(sram_addr_o) ? sram_mem[sram_addr_o] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) w[8*b +: 8] = sram_data_o[8*b +: 8];
            sram_mem[sram_addr_o] = w;
        end
    end

    // SRAM device: read data presented mid-cycle while CE and OE are low.
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_oe_n)
            sram_data_i <= sram_mem.exists(sram_addr_o) ? sram_mem[sram_addr_o] : 32'h0;
        else
            sram_data_i <= 32'h0BAD0BAD;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [19:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic ref_write(input logic [19:0] w, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] v;
        v = ref_read(w);
        for (int b = 0; b < 4; b++)
            if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
        ref_mem[w] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete Wishbone transfer. Request lines are scrambled once the
    // request has been taken; the transfer must not notice.
    task automatic xfer(input logic we, input logic [19:0] word,
                        input logic [31:0] wdata, input logic [3:0] sel);
        int ack_at, ce_lo, oe_lo, we_lo, doe, bad;
        logic [31:0] exp_rd;
        ack_at = -1; ce_lo = 0; oe_lo = 0; we_lo = 0; doe = 0; bad = 0;
        wishbone_cyc_i  = 1'b1;
        wishbone_stb_i  = 1'b1;
        wishbone_we_i   = we;
        wishbone_sel_i  = sel;
        wishbone_addr_i = {10'($urandom), word, 2'($urandom)};
        wishbone_data_i = wdata;
        for (int n = 1; n <= 40 && ack_at < 0; n++) begin
            tick();
            wishbone_stb_i  = 1'($urandom);
            wishbone_we_i   = 1'($urandom);
            wishbone_sel_i  = 4'($urandom);
            wishbone_addr_i = $urandom;
            wishbone_data_i = $urandom;
            if (!sram_ce_n) begin
                ce_lo++;
                if (sram_addr_o !== word || sram_be_n !== ~sel) bad++;
            end
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (sram_data_oe) begin
                doe++;
                if (sram_data_o !== wdata) bad++;
            end
            if (wishbone_ack_o) ack_at = n;
        end
        wishbone_cyc_i = 1'b0;
        wishbone_stb_i = 1'b0;
        txn++;
        if (!we) begin
            exp_rd = ref_read(word);
            check("rd_ack_cycle", ack_at, WRD + 1);
            check("rd_oe_cycles", oe_lo, WRD);
            check("rd_ce_cycles", ce_lo, WRD);
            check("rd_we_cycles", we_lo, 0);
            check("rd_data_oe", doe, 0);
            check("rd_addr_be", bad, 0);
            check("rd_data", wishbone_data_o, exp_rd);
            exp_data_o = exp_rd;
        end else if (sel == 4'h0) begin
            check("wr0_ack_cycle", ack_at, 1);
            check("wr0_ce_cycles", ce_lo, 0);
            check("wr0_we_cycles", we_lo, 0);
            check("wr0_data_o", wishbone_data_o, exp_data_o);
        end else begin
            check("wr_ack_cycle", ack_at, WWR + 2);
            check("wr_we_cycles", we_lo, WWR);
            check("wr_ce_cycles", ce_lo, WWR + 1);
            check("wr_oe_cycles", oe_lo, 0);
            check("wr_data_oe", doe, WWR + 1);
            check("wr_addr_be_data", bad, 0);
            check("wr_data_o_kept", wishbone_data_o, exp_data_o);
            ref_write(word, wdata, sel);
        end
        $display("txn %0d %s word=%05h sel=%b data=%08h ack_cycle=%0d data_o=%08h",
                 txn, we ? "WR" : "RD", word, sel, wdata, ack_at, wishbone_data_o);
        tick();
        check("ack_width", {31'b0, wishbone_ack_o}, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        int acks;

        rst = 1'b0;
        wishbone_cyc_i = 1'b0; wishbone_stb_i = 1'b0; wishbone_we_i = 1'b0;
        wishbone_sel_i = 4'h0; wishbone_addr_i = 32'h0; wishbone_data_i = 32'h0;
        exp_data_o = 32'h0;

        pool[0] = 20'h00004;
        pool[1] = 20'h00002;
        for (int i = 2; i < 7; i++) pool[i] = 20'($urandom);
        pool[7] = 20'hFFFFF;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            sram_mem[pool[i]] = d;
            ref_mem[pool[i]]  = d;
        end
        sram_mem[20'h4] = 32'hDEADBEEF;
        ref_mem[20'h4]  = 32'hDEADBEEF;

        // Reset state.
        repeat (3) tick();
        check("rst_ack", {31'b0, wishbone_ack_o}, 32'h0);
        check("rst_data_o", wishbone_data_o, 32'h0);
        check("rst_addr", {12'h0, sram_addr_o}, 32'h0);
        check("rst_sram_data", sram_data_o, 32'h0);
        check("rst_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
        check("rst_be_n", {28'h0, sram_be_n}, 32'hF);
        rst = 1'b1;
        tick();

        // Read of DEADBEEF at byte address 0x10.
        xfer(1'b0, 20'h4, 32'h0, 4'hF);
        // Two-byte write at byte address 8.
        xfer(1'b1, 20'h2, 32'h12345678, 4'b0011);
        // Zero-sel write must leave the SRAM untouched.
        xfer(1'b1, 20'h4, 32'h55AA55AA, 4'h0);
        xfer(1'b0, 20'h4, 32'h0, 4'hF);
        xfer(1'b0, 20'h2, 32'h0, 4'hF);
        // Back-to-back write then read of the same word.
        xfer(1'b1, pool[2], 32'hCAFEF00D, 4'b1111);
        xfer(1'b0, pool[2], 32'h0, 4'hF);

        // Master drops cyc in the first read cycle.
        wishbone_cyc_i = 1'b1; wishbone_stb_i = 1'b1; wishbone_we_i = 1'b0;
        wishbone_sel_i = 4'hF; wishbone_addr_i = {10'h0, pool[3], 2'b00};
        tick();
        check("rdabort_c1_ce", {31'b0, sram_ce_n}, 32'h0);
        wishbone_cyc_i = 1'b0; wishbone_stb_i = 1'b0;
        acks = 0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (i == 2)
                check("rdabort_c2_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
            acks += int'(wishbone_ack_o);
        end
        check("rdabort_no_ack", acks, 0);
        check("rdabort_data_o", wishbone_data_o, exp_data_o);
        $display("txn %0d RD-abort word=%05h acks=%0d", ++txn, pool[3], acks);

        // Master drops cyc in the first write cycle: hold cycle, no ack, write kept.
        d = $urandom;
        wishbone_cyc_i = 1'b1; wishbone_stb_i = 1'b1; wishbone_we_i = 1'b1;
        wishbone_sel_i = 4'b1010; wishbone_addr_i = {10'h0, pool[5], 2'b00};
        wishbone_data_i = d;
        tick();
        check("wrabort_c1", {29'h0, sram_ce_n, sram_we_n, sram_data_oe}, 32'h1);
        wishbone_cyc_i = 1'b0; wishbone_stb_i = 1'b0;
        tick();
        check("wrabort_hold", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'h7);
        check("wrabort_hold_data", sram_data_o, d);
        acks = int'(wishbone_ack_o);
        tick();
        check("wrabort_c3_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
        acks += int'(wishbone_ack_o);
        for (int i = 0; i < 2; i++) begin
            tick();
            acks += int'(wishbone_ack_o);
        end
        check("wrabort_no_ack", acks, 0);
        $display("txn %0d WR-abort word=%05h acks=%0d", ++txn, pool[5], acks);
        ref_write(pool[5], d, 4'b1010);
        xfer(1'b0, pool[5], 32'h0, 4'hF);

        // Reset asserted while the write pulse is active.
        wishbone_cyc_i = 1'b1; wishbone_stb_i = 1'b1; wishbone_we_i = 1'b1;
        wishbone_sel_i = 4'hF; wishbone_addr_i = {10'h0, pool[6], 2'b00};
        wishbone_data_i = 32'h0F0F0F0F;
        tick();
        check("rstmid_we_low", {31'b0, sram_we_n}, 32'h0);
        rst = 1'b0;
        #1;
        check("rstmid_strobes", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, wishbone_ack_o}, 32'h1C);
        check("rstmid_data_o", wishbone_data_o, 32'h0);
        wishbone_cyc_i = 1'b0; wishbone_stb_i = 1'b0;
        exp_data_o = 32'h0;
        tick();
        tick();
        rst = 1'b1;
        $display("txn %0d RST-abort word=%05h", ++txn, pool[6]);
        xfer(1'b0, pool[6], 32'h0, 4'hF);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            xfer(1'($urandom), pool[$urandom_range(0, 7)], $urandom, s);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wishbone_sram_slave.md
WISHBONE_SRAM_SLAVE -- requirements
Module: wishbone_sram_slave

Interface
REQ-001 SHALL provide parameter WAIT_RD, default 2, SRAM read strobe length in clk cycles (legal range 1..15).
REQ-002 SHALL provide parameter WAIT_WR, default 2, SRAM write-enable pulse length in clk cycles (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 wishbone_cyc_i  input  1  bus cycle valid.
REQ-006 wishbone_stb_i  input  1  transfer strobe.
REQ-007 wishbone_we_i  input  1  1 = write, 0 = read.
REQ-008 wishbone_sel_i  input  4  byte lane selects; bit n covers data[8n+7:8n].
REQ-009 wishbone_addr_i  input  32  byte address; bits [21:2] used, all other bits ignored.
REQ-010 wishbone_data_i  input  32  write data.
REQ-011 wishbone_data_o  output  32  read data, registered.
REQ-012 wishbone_ack_o  output  1  transfer complete, registered, one-cycle pulse.
REQ-013 sram_addr_o  output  20  SRAM word address.
REQ-014 sram_data_i  input  32  SRAM read data.
REQ-015 sram_data_o  output  32  SRAM write data.
REQ-016 sram_data_oe  output  1  1 = drive sram_data_o onto the pad.
REQ-017 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.
REQ-018 sram_be_n  output  4  active-low byte enables, equal to ~latched sel.

Function
REQ-019 All outputs SHALL be registered; the FSM SHALL have states IDLE, RD, WR, WR_HOLD, ACK.
REQ-020 In IDLE with cyc=1 and stb=1, SHALL latch addr[21:2], data, sel, and we, load the wait counter, and go to RD (we=0) or WR (we=1).
REQ-021 A write with sel=4'h0 SHALL go directly from IDLE to ACK: no strobe asserted, SRAM untouched.
REQ-022 RD: ce_n=0, oe_n=0, be_n=~sel, data_oe=0 for exactly WAIT_RD cycles; on the last RD cycle SHALL capture sram_data_i into wishbone_data_o, then go to ACK.
REQ-023 WR: ce_n=0, we_n=0, oe_n=1, data_oe=1, sram_data_o=latched data for exactly WAIT_WR cycles, then go to WR_HOLD.
REQ-024 WR_HOLD: one cycle with we_n=1, ce_n=0, data_oe=1 and address/data held (hold time), then go to ACK.
REQ-025 ACK: wishbone_ack_o=1 for exactly one cycle, all strobes deasserted, data_oe=0, then IDLE.
REQ-026 Latency from request sampled in IDLE (cycle 0) SHALL be: read ack at cycle WAIT_RD+1; write ack at cycle WAIT_WR+2; zero-sel write ack at cycle 1.
REQ-027 The wait counter SHALL be 4 bits, SHALL count down to 0, and SHALL never wrap.
REQ-028 wishbone_data_o SHALL hold its last captured value until the next read capture; writes SHALL NOT alter it.
REQ-029 If cyc falls during RD: go to IDLE next cycle, strobes deasserted, no ack, wishbone_data_o unchanged.
REQ-030 If cyc falls during WR: go to WR_HOLD, then IDLE with no ack; the partial write is accepted.
REQ-031 A request present in the cycle after ACK SHALL be accepted from IDLE as a new transfer (back-to-back allowed, one idle cycle between acks minimum).
REQ-032 stb/we/sel/addr/data changes after the request is latched SHALL be ignored until IDLE.
REQ-033 sram_addr_o and sram_be_n SHALL hold their last values in IDLE and ACK.

Reset
REQ-034 On rst=0, asynchronously: state IDLE, counter 0, wishbone_ack_o=0, wishbone_data_o=0, sram_addr_o=0, sram_data_o=0, sram_data_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF.
REQ-035 Reset mid-transfer SHALL abort immediately with no ack; the first request after rst returns to 1 SHALL be handled normally.

Verification
REQ-036 Read with WAIT_RD=2: sram_data_i=32'hDEADBEEF, addr=32'h00000010 -> sram_addr_o=20'h4, oe_n low for 2 cycles, ack at cycle 3, data_o=32'hDEADBEEF.
REQ-037 Write with WAIT_WR=2: addr=32'h0000_0008, data=32'h12345678, sel=4'b0011 -> be_n=4'b1100, we_n low for 2 cycles, one WR_HOLD cycle, ack at cycle 4.
REQ-038 Write with sel=4'h0 -> ack at cycle 1, ce_n/we_n never low.
REQ-039 Back-to-back write then read of the same address -> read returns the written data (with SRAM model); exactly two ack pulses, each one cycle wide.
REQ-040 cyc dropped at cycle 1 of a read -> no ack, strobes high by cycle 2, data_o unchanged; rst asserted mid-write -> all strobes high immediately, ack=0.
